vote_result_reader: RTL and testbench
=====================================

VOTE_RESULT_READER -- requirements
Module: vote_result_reader

Interface
REQ-001 SHALL have parameter HDR, default 8'hA5, meaning the frame header byte.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port mode, input, 1 bit; 1 = result mode, 0 = voting mode.
REQ-005 SHALL have port start, input, 1 bit; request a result readout.
REQ-006 SHALL have ports vote_count_1..vote_count_4, input, 8 bits each; live candidate tallies.
REQ-007 SHALL have port data_ready, input, 1 bit; downstream sink can accept a byte.
REQ-008 SHALL have port data_out, output, 8 bits; current frame byte.
REQ-009 SHALL have port data_valid, output, 1 bit; data_out holds a valid byte.
REQ-010 SHALL have port busy, output, 1 bit; a readout is in progress.
REQ-011 SHALL have port done, output, 1 bit; one-cycle pulse when a frame completes.
REQ-012 SHALL have port led_result, output, 8 bits; last completed result byte.

Function
REQ-013 SHALL use states IDLE, COMPARE, SEND and FINISH.
REQ-014 IDLE: on start=1 and mode=1 SHALL capture all four counts into snapshot registers on that edge and go to COMPARE; start with mode=0 SHALL be ignored.
REQ-015 COMPARE: SHALL take exactly one cycle, registering max count, one-hot winner[3:0] (bit i set if snapshot i equals max) and tie (more than one winner bit set); then go to SEND with byte index 0.
REQ-016 If all snapshots are 0, SHALL give winner=4'b0000 and tie=0.
REQ-017 Result byte SHALL be {tie, 3'b000, winner[3:0]}; winner bit 0 = candidate 1.
REQ-018 SEND: frame SHALL be 6 bytes in order: HDR, count1, count2, count3, count4, result byte.
REQ-019 In SEND, data_valid SHALL be 1 and data_out SHALL hold the indexed byte, stable until accepted.
REQ-020 A byte SHALL be accepted on a cycle with data_valid=1 and data_ready=1; index advances next cycle, with no bubble between bytes.
REQ-021 Acceptance of byte index 5 SHALL move the FSM to FINISH.
REQ-022 FINISH: for one cycle SHALL assert done=1, load led_result with the result byte, then return to IDLE.
REQ-023 busy SHALL be 1 in COMPARE, SEND and FINISH, and 0 in IDLE.
REQ-024 Counts changing after capture SHALL not affect the frame in progress.
REQ-025 start while busy SHALL be ignored; there is no queuing.
REQ-026 mode falling to 0 in COMPARE or SEND SHALL abort: next cycle IDLE, data_valid=0, no done, led_result unchanged.
REQ-027 data_ready held at 0 SHALL stall indefinitely without a timeout.
REQ-028 With data_ready held at 1, latency SHALL be: start edge N, COMPARE N+1, header valid N+2, last byte N+7, done N+8.

Reset
REQ-029 On reset=1 at a clock edge, state SHALL be IDLE and data_out=0, data_valid=0, busy=0, done=0, led_result=0, with snapshots, index and winner cleared.
REQ-030 Reset SHALL take priority over start, mode and data_ready, including mid-frame; the partial frame is discarded.

Verification
REQ-031 Counts 3,7,2,5, mode=1, start pulse, data_ready=1 -> bytes A5,03,07,02,05,02 on consecutive cycles, done at N+8, led_result=8'h02.
REQ-032 Counts 4,9,9,1 -> result byte 8'h86 (tie=1, winner=0110); all counts 0 -> result byte 8'h00.
REQ-033 data_ready toggles 1,0,0,1 during SEND -> each byte held stable while stalled; exactly 6 handshakes; no duplicated or skipped byte.
REQ-034 mode=0 with start=1 -> busy stays 0; then mode drops to 0 at byte index 2 -> data_valid=0 next cycle, no done, led_result keeps its old value.
REQ-035 Counts change during SEND -> frame carries the snapshot values; start re-pulsed while busy -> no effect.
REQ-036 Reset asserted at byte index 3 -> next cycle all outputs 0, IDLE; a fresh start then yields a complete frame beginning with A5.

Source files
------------

// File: rtl/vote_result_reader.sv
// ---------------------------------------------------------------------------
// vote_result_reader
//
// Purpose:
//    On a start request in result mode, freezes the four live candidate
//    tallies, works out the winner(s) in one cycle, then streams a 6-byte
//    frame to a ready/valid sink:
//       HDR, count1, count2, count3, count4, {tie, 3'b000, winner[3:0]}
//    When the last byte is accepted, done pulses for one cycle and the
//    result byte is latched onto led_result.
//
// Ports:
//    clk                        system clock, rising edge
//    reset                      synchronous, active-high
//    mode                       1 = result mode, 0 = voting mode
//    start                      request a readout (honoured only in IDLE)
//    vote_count_1..vote_count_4 live tallies
//    data_ready                 sink can take a byte this cycle
//    data_out                   current frame byte
//    data_valid                 data_out holds a valid byte
//    busy                       readout in progress
//    done                       one-cycle pulse at end of frame
//    led_result                 last completed result byte
// ---------------------------------------------------------------------------
module vote_result_reader #(
   parameter logic [7:0] HDR = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode,
   input  logic       start,
   input  logic [7:0] vote_count_1,
   input  logic [7:0] vote_count_2,
   input  logic [7:0] vote_count_3,
   input  logic [7:0] vote_count_4,
   input  logic       data_ready,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] led_result
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      SEND    = 2'd2,
      FINISH  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [7:0] snap_1;
   logic [7:0] snap_2;
   logic [7:0] snap_3;
   logic [7:0] snap_4;
   logic [3:0] winner;
   logic       tie;
   logic [2:0] idx;

   logic [7:0] max_c;
   logic [3:0] winner_c;
   logic       tie_c;
   logic [7:0] result_byte;
   logic [7:0] frame_byte;

   // Winner search over the frozen snapshots. The maximum only feeds the
   // winner mask inside the COMPARE cycle, so it is not kept as state.
   // A zero maximum means nobody has any votes: no winner and no tie.
   // Clearing the lowest set bit of the mask leaves something only when
   // two or more candidates share the maximum.
   always_comb begin
      max_c = snap_1;
      if (snap_2 > max_c) max_c = snap_2;
      if (snap_3 > max_c) max_c = snap_3;
      if (snap_4 > max_c) max_c = snap_4;
      winner_c = 4'b0000;
      if (max_c != 8'd0) begin
         winner_c[0] = (snap_1 == max_c);
         winner_c[1] = (snap_2 == max_c);
         winner_c[2] = (snap_3 == max_c);
         winner_c[3] = (snap_4 == max_c);
      end
      tie_c = ((winner_c & (winner_c - 4'd1)) != 4'b0000);
   end

   assign result_byte = {tie, 3'b000, winner};

   // Byte selected by the frame index; only meaningful in SEND.
   always_comb begin
      case (idx)
         3'd0:    frame_byte = HDR;
         3'd1:    frame_byte = snap_1;
         3'd2:    frame_byte = snap_2;
         3'd3:    frame_byte = snap_3;
         3'd4:    frame_byte = snap_4;
         3'd5:    frame_byte = result_byte;
         default: frame_byte = 8'h00;
      endcase
   end

   // Next-state and output decode. Dropping out of result mode while
   // comparing or sending abandons the frame straight back to IDLE, and
   // that check wins over a handshake in the same cycle.
   always_comb begin
      state_next = state;
      data_out   = 8'h00;
      data_valid = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && mode) state_next = COMPARE;
         end
         COMPARE: begin
            if (!mode) state_next = IDLE;
            else       state_next = SEND;
         end
         SEND: begin
            data_valid = 1'b1;
            data_out   = frame_byte;
            if (!mode)                         state_next = IDLE;
            else if (data_ready && idx == 3'd5) state_next = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus datapath. Snapshots are taken only on the edge
   // that leaves IDLE, so tallies moving later cannot leak into the frame.
   // led_result is loaded on the edge that enters FINISH, so it already
   // shows the new result while done is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         snap_1     <= 8'h00;
         snap_2     <= 8'h00;
         snap_3     <= 8'h00;
         snap_4     <= 8'h00;
         winner     <= 4'b0000;
         tie        <= 1'b0;
         idx        <= 3'd0;
         led_result <= 8'h00;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               idx <= 3'd0;
               if (start && mode) begin
                  snap_1 <= vote_count_1;
                  snap_2 <= vote_count_2;
                  snap_3 <= vote_count_3;
                  snap_4 <= vote_count_4;
               end
            end
            COMPARE: begin
               winner <= winner_c;
               tie    <= tie_c;
               idx    <= 3'd0;
            end
            SEND: begin
               if (mode && data_ready) begin
                  idx <= idx + 3'd1;
                  if (idx == 3'd5) led_result <= result_byte;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_result_reader.sv
// ---------------------------------------------------------------------------
// tb_vote_result_reader
//
// Bench for vote_result_reader. Each frame pushes its six expected bytes
// into a queue when it is started; a monitor pops and compares a byte on
// every handshake. A table of tally sets drives full-speed frames, and
// hand-written sequences cover stalls, tally changes mid-frame, start
// while busy, mode abort and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_vote_result_reader;

   logic       clk;
   logic       reset;
   logic       mode;
   logic       start;
   logic [7:0] vote_count_1;
   logic [7:0] vote_count_2;
   logic [7:0] vote_count_3;
   logic [7:0] vote_count_4;
   logic       data_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic       busy;
   logic       done;
   logic [7:0] led_result;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] exp_q[$];
   int         handshakes = 0;
   int         done_count = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_out   = 8'h00;

   typedef struct {
      logic [7:0] c1;
      logic [7:0] c2;
      logic [7:0] c3;
      logic [7:0] c4;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[6];

   vote_result_reader #(.HDR(8'hA5)) dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .start        (start),
      .vote_count_1 (vote_count_1),
      .vote_count_2 (vote_count_2),
      .vote_count_3 (vote_count_3),
      .vote_count_4 (vote_count_4),
      .data_ready   (data_ready),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .busy         (busy),
      .done         (done),
      .led_result   (led_result)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports any miss
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Handshake monitor: pops one expected byte per accepted byte and
   // checks that a stalled byte is still the same one on the next cycle
   always @(negedge clk) begin
      if (stall_prev && data_valid)
         checkOutput("stall_hold", {24'd0, data_out}, {24'd0, prev_out});
      if (data_valid && data_ready) begin
         handshakes++;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_byte", 32'd1, 32'd0);
         end else begin
            checkOutput("frame_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
         end
      end
      if (done) done_count++;
      stall_prev = data_valid && !data_ready;
      prev_out   = data_out;
   end

   // Loads tallies, queues the expected frame, pulses start; returns #1
   // after the capture edge
   task automatic applyStimulus(input logic [7:0] c1, input logic [7:0] c2,
                                input logic [7:0] c3, input logic [7:0] c4,
                                input logic [7:0] res);
      vote_count_1 = c1;
      vote_count_2 = c2;
      vote_count_3 = c3;
      vote_count_4 = c4;
      mode         = 1'b1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(c1);
      exp_q.push_back(c2);
      exp_q.push_back(c3);
      exp_q.push_back(c4);
      exp_q.push_back(res);
      handshakes = 0;
      done_count = 0;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // Full-speed frame with cycle-exact timing checks. With disturb set,
   // tallies are changed and start is re-pulsed while the frame runs.
   task automatic runFrame(input vec_t v, input bit disturb);
      data_ready = 1'b1;
      applyStimulus(v.c1, v.c2, v.c3, v.c4, v.res);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         checkOutput($sformatf("valid_k%0d", k), {31'd0, data_valid},
                     {31'd0, (k >= 2 && k <= 7)});
         checkOutput($sformatf("done_k%0d", k), {31'd0, done}, {31'd0, (k == 8)});
         checkOutput($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, (k <= 8)});
         @(posedge clk); #1;
         if (disturb && k == 1) begin
            vote_count_1 = 8'd200;
            vote_count_2 = 8'd201;
            vote_count_3 = 8'd202;
            vote_count_4 = 8'd203;
         end
         if (disturb) start = (k == 3);
      end
      checkOutput("led_result", {24'd0, led_result}, {24'd0, v.res});
      checkOutput("handshakes", handshakes, 32'd6);
      checkOutput("done_pulses", done_count, 32'd1);
      if (disturb) begin
         @(negedge clk);
         checkOutput("no_requeue_busy", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // Waits (bounded) until the first frame byte is presented
   task automatic waitValid();
      int n = 0;
      @(negedge clk);
      while (!data_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("valid_seen", {31'd0, data_valid}, 32'd1);
   endtask

   initial begin
      logic [7:0] old_led;
      logic       pat[4];
      vec_t       v;

      vecs[0] = '{c1: 8'd3,   c2: 8'd7, c3: 8'd2, c4: 8'd5,   res: 8'h02};
      vecs[1] = '{c1: 8'd4,   c2: 8'd9, c3: 8'd9, c4: 8'd1,   res: 8'h86};
      vecs[2] = '{c1: 8'd0,   c2: 8'd0, c3: 8'd0, c4: 8'd0,   res: 8'h00};
      vecs[3] = '{c1: 8'd8,   c2: 8'd8, c3: 8'd8, c4: 8'd8,   res: 8'h8F};
      vecs[4] = '{c1: 8'd255, c2: 8'd0, c3: 8'd0, c4: 8'd255, res: 8'h89};
      vecs[5] = '{c1: 8'd1,   c2: 8'd2, c3: 8'd3, c4: 8'd4,   res: 8'h08};

      reset        = 1'b1;
      mode         = 1'b0;
      start        = 1'b0;
      data_ready   = 1'b0;
      vote_count_1 = 8'd0;
      vote_count_2 = 8'd0;
      vote_count_3 = 8'd0;
      vote_count_4 = 8'd0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
      checkOutput("rst_valid", {31'd0, data_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_led", {24'd0, led_result}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Table of full-speed frames
      for (int i = 0; i < 6; i++) runFrame(vecs[i], 1'b0);

      // Start in voting mode is ignored
      mode  = 1'b0;
      start = 1'b1;
      vote_count_1 = 8'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("mode0_busy", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
         start = 1'b0;
      end

      // Stall pattern 1,0,0,1 throughout the frame
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      data_ready = 1'b0;
      applyStimulus(8'd6, 8'd6, 8'd1, 8'd2, 8'h83);
      for (int i = 0; i < 60 && done_count == 0; i++) begin
         data_ready = pat[i % 4];
         @(posedge clk); #1;
      end
      checkOutput("stall_handshakes", handshakes, 32'd6);
      checkOutput("stall_done", done_count, 32'd1);
      checkOutput("stall_q_empty", exp_q.size(), 32'd0);
      checkOutput("stall_led", {24'd0, led_result}, 32'h83);

      // Tallies change mid-frame and start re-pulsed while busy
      v = '{c1: 8'd10, c2: 8'd20, c3: 8'd30, c4: 8'd40, res: 8'h08};
      runFrame(v, 1'b1);

      // Mode drops at byte index 2
      old_led    = led_result;
      data_ready = 1'b0;
      applyStimulus(8'd1, 8'd1, 8'd5, 8'd1, 8'h04);
      waitValid();
      @(posedge clk); #1;
      data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      data_ready = 1'b0;
      mode       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_valid", {31'd0, data_valid}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", done_count, 32'd0);
      checkOutput("abort_led", {24'd0, led_result}, {24'd0, old_led});
      checkOutput("abort_left", exp_q.size(), 32'd4);
      exp_q.delete();
      @(posedge clk); #1;

      // Reset at byte index 3, then a fresh frame
      data_ready = 1'b0;
      applyStimulus(8'd12, 8'd34, 8'd56, 8'd78, 8'h08);
      waitValid();
      @(posedge clk); #1;
      data_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      data_ready = 1'b0;
      reset      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_data_out", {24'd0, data_out}, 32'd0);
      checkOutput("midrst_valid", {31'd0, data_valid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_done", {31'd0, done}, 32'd0);
      checkOutput("midrst_led", {24'd0, led_result}, 32'd0);
      checkOutput("midrst_left", exp_q.size(), 32'd3);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      v = '{c1: 8'd5, c2: 8'd4, c3: 8'd3, c4: 8'd2, res: 8'h01};
      runFrame(v, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
